// File: rtl/sram_master_pkg.sv
// Shared types and constants for sram_master.
// The optional alignment check is enabled with `define SRAM_MASTER_ALIGN_CHECK_EN.
package sram_master_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // The phase counter must be able to hold the longer of the two phase lengths.
  function automatic int ctr_width(input int wait_c, input int hold_c);
    int m;
    m = (wait_c > hold_c) ? wait_c : hold_c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_phase_ctr.sv
// Loadable down-counter used to time the ACCESS and HOLD phases.
// The done output is high when the count has reached zero.
module sram_phase_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_master.sv
// Single-beat load/store master driving cs/oe/we strobes of an asynchronous SRAM.
// Optional macro SRAM_MASTER_ALIGN_CHECK_EN rejects requests with addr[1:0] != 0.
module sram_master
  import sram_master_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output state_t            dbg_state
);

  localparam int CW = ctr_width(WAIT_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  state_t        state, state_n;
  logic          we_r;
  logic          accept, misaligned;
  logic          ctr_load, ctr_done;
  logic [CW-1:0] ctr_load_val;
  logic          rsp_fire, capture;

  // Handshake: a request transfers at a rising edge where req_valid && req_ready;
  // req_* must be stable only in that cycle. Responses are single-cycle pulses
  // with no backpressure.
  assign accept = req_valid && req_ready;

`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  assign misaligned = (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  sram_phase_ctr #(.W(CW)) u_phase_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .done     (ctr_done)
  );

  always_comb begin
    state_n      = state;
    ctr_load     = 1'b0;
    ctr_load_val = WAIT_LD;
    case (state)
      IDLE:   if (accept) state_n = misaligned ? ERR : SETUP;
      SETUP: begin
        state_n  = ACCESS;
        ctr_load = 1'b1;
      end
      ACCESS: begin
        if (ctr_done) begin
          if (HOLD_CYCLES > 0) begin
            state_n      = HOLD;
            ctr_load     = 1'b1;
            ctr_load_val = HOLD_LD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      HOLD:    if (ctr_done) state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rsp_fire  = ((state == ACCESS) || (state == HOLD)) && (state_n == IDLE);
  assign capture   = (state == ACCESS) && ctr_done && !we_r;
  assign dbg_state = state;

  // Outputs are decoded from the next state so every pin comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_r      <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      sram_cs   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
      sram_cs   <= (state_n == SETUP) || (state_n == ACCESS) || (state_n == HOLD);
      sram_oe   <= (state_n == ACCESS) && !we_r;
      sram_we   <= (state_n == ACCESS) && we_r;
      rsp_valid <= rsp_fire || (state_n == ERR);
      rsp_err   <= (state_n == ERR);
      if (accept) begin
        we_r <= req_we;
        if (!misaligned) begin
          sram_addr <= req_addr;
          sram_din  <= req_wdata;
        end
      end
      if (capture) begin
        rsp_rdata <= sram_dout;
      end else if ((rsp_fire && we_r) || (state_n == ERR)) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/sram_master.md
Name: sram_master

Overview:
- Synchronous initiator that turns single-beat load/store requests from the pipeline MEM stage into cs/oe/we/addr/din strobe sequences for the asynchronous sram model.
- Captures read data from sram dout and returns it as a one-cycle response.
- Sits between the MEM stage and data memory; the only block that drives the sram pins.

Parameters:
- ADDR_W, 32, request/sram address width
- DATA_W, 32, data width
- WAIT_CYCLES, 2, cycles strobe (oe or we) is held asserted; legal range >= 1
- HOLD_CYCLES, 1, cycles cs/addr/din held after strobe deasserts; 0 legal (phase skipped)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master can accept; transfer on req_valid&&req_ready at clk edge
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  DATA_W  load data; 0 for stores
- rsp_err  out  1  error flag, qualified by rsp_valid
- busy  out  1  transaction in flight (state != IDLE)
- sram_cs  out  1  chip select
- sram_oe  out  1  output enable
- sram_we  out  1  write enable
- sram_addr  out  ADDR_W  address to sram
- sram_din  out  DATA_W  write data to sram
- sram_dout  in  DATA_W  read data from sram

Behaviour:
- All outputs registered. Reset (rst_n=0, async) clears state to IDLE and drives req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and all sram_* outputs to 0. req_ready rises in the first cycle after reset release.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: req_ready=1. On accept, register we, addr and wdata. Later changes on req_* are ignored until the next accept. Next state is SETUP.
- SETUP (1 cycle): sram_cs=1, sram_addr/sram_din valid, oe=0, we=0. Addr is stable before any strobe edge, so the sram sees exactly one write event per store. Next state is ACCESS with the counter loaded to WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): cs=1; we=stored we; oe=!stored we. The counter decrements each cycle. At the final ACCESS edge, a load captures sram_dout into rsp_rdata. Next state is HOLD if HOLD_CYCLES>0, else IDLE.
- HOLD (HOLD_CYCLES cycles): cs=1, oe=0, we=0, addr/din held. Next state is IDLE.
- Exiting to IDLE: cs=0, addr/din keep their last values, and rsp_valid=1 for exactly one cycle. That cycle is also the first IDLE cycle with req_ready=1, so back-to-back requests accept at the same edge.
- Latency from the accept edge to the rsp_valid cycle is 2+WAIT_CYCLES+HOLD_CYCLES cycles (5 at defaults). Throughput is one transaction per 2+WAIT_CYCLES+HOLD_CYCLES cycles.
- oe and we are never both 1. The strobe is never asserted while cs=0.
- rsp_rdata holds its value until the next load response. Store responses drive rsp_rdata=0.
- Reset mid-transaction: everything clears immediately; the in-flight request is dropped, no response is issued, and any partial write is undefined.
- Counter width is $clog2 of max(WAIT_CYCLES,HOLD_CYCLES)+1.

Optional Feature:
- Macro SRAM_MASTER_ALIGN_CHECK_EN.
- Defined: an accepted request with addr[1:0]!=0 causes no sram activity (sram_* stay idle). The FSM goes to a 1-cycle ERR response state, then rsp_valid=1, rsp_err=1, rsp_rdata=0 on the cycle after accept, and req_ready returns the next cycle.
- Not defined: rsp_err is constant 0, no alignment check is made, and the address is passed unchanged.

Decomposition:
- Package sram_master_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, HOLD, ERR);
  - default ADDR_W/DATA_W constants;
  - the localparam function computing counter width.
- One sub-module, sram_phase_ctr: a loadable down-counter with a done flag, reused for the ACCESS and HOLD phases. The FSM stays in sram_master.

Test Plan:
- Store addr=0x10, wdata=0xDEADBEEF, default params → SETUP 1 cycle, we=1 for exactly 2 cycles, oe=0 throughout; rsp_valid 5 cycles after accept with rsp_rdata=0, rsp_err=0.
- Load addr=0x10 after that store → oe=1 for 2 cycles, we=0; rsp_rdata=0xDEADBEEF at latency 5.
- Back-to-back: req_valid held high for a load then a store → the second accept occurs in the rsp_valid cycle of the first; no idle gap, cs low for exactly that one cycle.
- WAIT_CYCLES=4, HOLD_CYCLES=0 → latency 6, no HOLD cycle, cs drops right after the strobe.
- Drop rst_n during ACCESS of a store → all outputs 0 immediately, no rsp_valid; req_ready=1 one cycle after release, and a fresh load completes normally.
- With SRAM_MASTER_ALIGN_CHECK_EN, load addr=0x13 → sram_cs never asserts; rsp_valid=1, rsp_err=1 one cycle after accept. Without the macro, the same stimulus performs a normal read at 0x13 with rsp_err=0.
